cvxif_issue_initiator: RTL and testbench
========================================

Name: cvxif_issue_initiator

Overview:
- Core-side initiator of the CV-X-IF issue/commit/result exchange.
- Takes one offload candidate from the core's issue stage and drives the issue request until the coprocessor handshakes it.
- Captures the accept/writeback decision, sends the commit (or kill), and collects the matching result.
- Hands the result to core writeback as a single-cycle pulse. One instruction in flight at a time.

Parameters:
- XLEN, 64, operand/result data width.
- IdWidth, 3, instruction id width.
- TimeoutCycles, 255, watchdog limit in WAIT_RES (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  pipeline flush; kills the in-flight instruction.
- offload_valid_i  in  1  core has an instruction to offload.
- offload_ready_o  out  1  initiator can capture an instruction.
- offload_instr_i  in  32  instruction word.
- offload_rs0_i  in  XLEN  source operand 0.
- offload_rs1_i  in  XLEN  source operand 1.
- offload_id_i  in  IdWidth  instruction id.
- x_issue_valid_o  out  1  issue request valid.
- x_issue_ready_i  in  1  coprocessor ready.
- x_issue_instr_o  out  32  instruction word driven on the issue interface.
- x_issue_rs0_o  out  XLEN  operand 0 driven on the issue interface.
- x_issue_rs1_o  out  XLEN  operand 1 driven on the issue interface.
- x_issue_id_o  out  IdWidth  id driven on the issue interface.
- x_issue_accept_i  in  1  response: instruction accepted.
- x_issue_writeback_i  in  1  response: result will be returned.
- x_commit_valid_o  out  1  commit strobe.
- x_commit_id_o  out  IdWidth  id being committed.
- x_commit_kill_o  out  1  commit is a kill.
- x_result_valid_i  in  1  result valid.
- x_result_ready_o  out  1  initiator accepts the result.
- x_result_id_i  in  IdWidth  result id.
- x_result_data_i  in  XLEN  result data.
- x_result_rd_i  in  5  destination register.
- x_result_we_i  in  1  result write enable.
- wb_valid_o  out  1  writeback pulse to the core.
- wb_id_o  out  IdWidth  id of the written-back instruction.
- wb_data_o  out  XLEN  writeback data.
- wb_rd_o  out  5  writeback destination register.
- wb_we_o  out  1  writeback write enable.
- wb_exc_o  out  1  illegal instruction (not accepted) or timeout.
- busy_o  out  1  state is not IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs 0 except offload_ready_o=1.
  - Captured instruction, operand and id registers cleared to 0.
- States: IDLE, ISSUE, COMMIT, WAIT_RES, RESP.
- IDLE:
  - offload_ready_o = ~flush_i.
  - On offload_valid_i & offload_ready_o: capture instr/rs0/rs1/id, go to ISSUE.
  - x_issue_valid_o rises the cycle after capture.
- ISSUE:
  - x_issue_valid_o=1; instr/rs/id outputs held stable from capture.
  - Valid is never dropped before x_issue_ready_i, including under flush_i.
  - On handshake, latch accept, writeback and a kill flag (flush_i now or flush seen since capture), then go to COMMIT.
  - If accept=0: skip COMMIT, go to RESP with wb_exc_o=1, wb_we_o=0 (no wb pulse if killed).
- COMMIT, one cycle:
  - x_commit_valid_o=1, x_commit_id_o = captured id.
  - x_commit_kill_o = kill flag | flush_i.
  - Killed: go to IDLE, no writeback.
  - Not killed and writeback=1: go to WAIT_RES.
  - Not killed and writeback=0: go to RESP with wb_we_o=0, wb_exc_o=0.
- WAIT_RES:
  - x_result_ready_o=1.
  - Result with matching id: register data/rd/we, go to RESP.
  - Result with non-matching id: consumed and discarded; remain in WAIT_RES.
  - flush_i here sets a drop flag: the matching result is consumed, then go to IDLE with no wb pulse.
- RESP: wb_valid_o=1 for exactly one cycle with the registered fields, then go to IDLE.
- wb_* fields hold their last value when wb_valid_o=0.
- Latency, ready asserted on first opportunity, no flush: offload handshake at cycle 0 -> issue valid at cycle 1 -> commit at cycle 2 -> result accepted at cycle 3 at the earliest -> wb_valid_o at cycle 4.
- Reset mid-operation: immediate return to IDLE; the outstanding coprocessor instruction is abandoned, with no commit and no wb.

Optional Feature:
- Macro: CVXIF_ISSUE_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT_RES and increments each cycle there.
  - On reaching TimeoutCycles, go to RESP with wb_exc_o=1, wb_we_o=0, and set a stale flag.
  - While the stale flag is set, the next result with the stale id is consumed and discarded; the flag is cleared by that result or by reset.
- Undefined: no counter; WAIT_RES waits indefinitely.

Test Plan:
- Accepted writeback instruction:
  - Stimulus: offload instr 0x0000_200B, id 2, rs0=5, rs1=7; ready=1, accept=1, writeback=1; result id 2, data 0xC, rd 10, we=1 at the first WAIT_RES cycle.
  - Required: commit id 2, kill=0; one wb pulse at cycle 4 with data 0xC, rd 10.
- Issue backpressure: x_issue_ready_i held low 5 cycles -> x_issue_valid_o stays 1 with instr/rs/id unchanged; commit follows the handshake by exactly one cycle.
- Rejected instruction: accept=0 -> no commit; single wb pulse with wb_exc_o=1, wb_we_o=0; busy_o low the following cycle.
- Flush in ISSUE: flush_i pulsed while ready=0, handshake 3 cycles later -> commit with kill=1; no wb pulse; return to IDLE.
- Wrong-id result: result id 5 arrives while waiting on id 2, then id 2 with data 0x33 -> id 5 consumed silently; one wb pulse with data 0x33.
- Timeout (macro defined), TimeoutCycles=4: no result for 4 cycles -> wb pulse with exc=1; a late result id 2 is consumed and produces no wb pulse.

Source files
------------

// File: rtl/cvxif_issue_initiator.sv
// Core-side initiator of the CV-X-IF issue/commit/result exchange.
// One instruction is in flight at a time: it is captured from the core, issued
// until the coprocessor handshakes it, committed (or killed), and its result is
// handed to core writeback as a single-cycle wb_valid_o pulse.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             pipeline flush, kills the in-flight instruction
//   offload_*           candidate instruction from the core issue stage
//   x_issue_*           CV-X-IF issue request/response
//   x_commit_*          CV-X-IF commit strobe (with kill)
//   x_result_*          CV-X-IF result channel
//   wb_*                writeback pulse and fields to the core
//   busy_o              an instruction is in flight
//
// Optional feature CVXIF_ISSUE_TIMEOUT_EN: a watchdog abandons WAIT_RES after
// TimeoutCycles cycles, reports an exception, and discards the late result.
module cvxif_issue_initiator #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned IdWidth       = 3,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               offload_valid_i,
  output logic               offload_ready_o,
  input  logic [31:0]        offload_instr_i,
  input  logic [XLEN-1:0]    offload_rs0_i,
  input  logic [XLEN-1:0]    offload_rs1_i,
  input  logic [IdWidth-1:0] offload_id_i,
  output logic               x_issue_valid_o,
  input  logic               x_issue_ready_i,
  output logic [31:0]        x_issue_instr_o,
  output logic [XLEN-1:0]    x_issue_rs0_o,
  output logic [XLEN-1:0]    x_issue_rs1_o,
  output logic [IdWidth-1:0] x_issue_id_o,
  input  logic               x_issue_accept_i,
  input  logic               x_issue_writeback_i,
  output logic               x_commit_valid_o,
  output logic [IdWidth-1:0] x_commit_id_o,
  output logic               x_commit_kill_o,
  input  logic               x_result_valid_i,
  output logic               x_result_ready_o,
  input  logic [IdWidth-1:0] x_result_id_i,
  input  logic [XLEN-1:0]    x_result_data_i,
  input  logic [4:0]         x_result_rd_i,
  input  logic               x_result_we_i,
  output logic               wb_valid_o,
  output logic [IdWidth-1:0] wb_id_o,
  output logic [XLEN-1:0]    wb_data_o,
  output logic [4:0]         wb_rd_o,
  output logic               wb_we_o,
  output logic               wb_exc_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {StIdle, StIssue, StCommit, StWaitRes, StResp} state_e;

  state_e             state_q, state_d;
  logic [31:0]        instr_q, instr_d;
  logic [XLEN-1:0]    rs0_q, rs0_d, rs1_q, rs1_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic               kill_q, kill_d;   // flush seen since capture
  logic               wbk_q, wbk_d;     // coprocessor will return a result
  logic               drop_q, drop_d;   // flushed while waiting: swallow the result
  logic [IdWidth-1:0] wb_id_q, wb_id_d;
  logic [XLEN-1:0]    wb_data_q, wb_data_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic               wb_we_q, wb_we_d, wb_exc_q, wb_exc_d;
  logic               res_stale;

`ifdef CVXIF_ISSUE_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TimeoutCycles + 1) > 8) ?
                                 $clog2(TimeoutCycles + 1) : 8;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               stale_q, stale_d;
  logic [IdWidth-1:0] stale_id_q, stale_id_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      instr_q   <= '0;
      rs0_q     <= '0;
      rs1_q     <= '0;
      id_q      <= '0;
      kill_q    <= 1'b0;
      wbk_q     <= 1'b0;
      drop_q    <= 1'b0;
      wb_id_q   <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      wb_exc_q  <= 1'b0;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
      cnt_q      <= '0;
      stale_q    <= 1'b0;
      stale_id_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      rs0_q     <= rs0_d;
      rs1_q     <= rs1_d;
      id_q      <= id_d;
      kill_q    <= kill_d;
      wbk_q     <= wbk_d;
      drop_q    <= drop_d;
      wb_id_q   <= wb_id_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      wb_exc_q  <= wb_exc_d;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
      cnt_q      <= cnt_d;
      stale_q    <= stale_d;
      stale_id_q <= stale_id_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    rs0_d     = rs0_q;
    rs1_d     = rs1_q;
    id_d      = id_q;
    kill_d    = kill_q;
    wbk_d     = wbk_q;
    drop_d    = drop_q;
    wb_id_d   = wb_id_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_we_d   = wb_we_q;
    wb_exc_d  = wb_exc_q;
    offload_ready_o  = 1'b0;
    x_issue_valid_o  = 1'b0;
    x_commit_valid_o = 1'b0;
    x_commit_kill_o  = 1'b0;
    x_result_ready_o = 1'b0;
    wb_valid_o       = 1'b0;
    res_stale        = 1'b0;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
    cnt_d      = cnt_q;
    stale_d    = stale_q;
    stale_id_d = stale_id_q;
    // A timed-out result is drained in any state, even with nothing in flight.
    x_result_ready_o = stale_q;
    res_stale        = stale_q && (x_result_id_i == stale_id_q);
    if (x_result_valid_i && res_stale) stale_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        offload_ready_o = ~flush_i;
        if (offload_valid_i && !flush_i) begin
          instr_d = offload_instr_i;
          rs0_d   = offload_rs0_i;
          rs1_d   = offload_rs1_i;
          id_d    = offload_id_i;
          kill_d  = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Valid stays up until the handshake even under flush; a flush only
        // turns the eventual commit into a kill.
        x_issue_valid_o = 1'b1;
        kill_d          = kill_q | flush_i;
        if (x_issue_ready_i) begin
          wbk_d = x_issue_writeback_i;
          if (x_issue_accept_i) begin
            state_d = StCommit;
          end else if (kill_q || flush_i) begin
            state_d = StIdle;
          end else begin
            state_d   = StResp;
            wb_id_d   = id_q;
            wb_data_d = '0;
            wb_rd_d   = '0;
            wb_we_d   = 1'b0;
            wb_exc_d  = 1'b1;
          end
        end
      end
      StCommit: begin
        x_commit_valid_o = 1'b1;
        x_commit_kill_o  = kill_q | flush_i;
        if (kill_q || flush_i) begin
          state_d = StIdle;
        end else if (wbk_q) begin
          state_d = StWaitRes;
          drop_d  = 1'b0;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
          cnt_d = '0;
`endif
        end else begin
          state_d   = StResp;
          wb_id_d   = id_q;
          wb_data_d = '0;
          wb_rd_d   = '0;
          wb_we_d   = 1'b0;
          wb_exc_d  = 1'b0;
        end
      end
      StWaitRes: begin
        x_result_ready_o = 1'b1;
        drop_d           = drop_q | flush_i;
        // Non-matching results are accepted and simply ignored.
        if (x_result_valid_i && !res_stale && (x_result_id_i == id_q)) begin
          if (drop_q || flush_i) begin
            state_d = StIdle;
          end else begin
            state_d   = StResp;
            wb_id_d   = id_q;
            wb_data_d = x_result_data_i;
            wb_rd_d   = x_result_rd_i;
            wb_we_d   = x_result_we_i;
            wb_exc_d  = 1'b0;
          end
        end
`ifdef CVXIF_ISSUE_TIMEOUT_EN
        cnt_d = cnt_q + CntW'(1);
        if (state_d == StWaitRes && cnt_q == CntW'(TimeoutCycles - 1)) begin
          stale_d    = 1'b1;
          stale_id_d = id_q;
          if (drop_q || flush_i) begin
            state_d = StIdle;
          end else begin
            state_d   = StResp;
            wb_id_d   = id_q;
            wb_data_d = '0;
            wb_rd_d   = '0;
            wb_we_d   = 1'b0;
            wb_exc_d  = 1'b1;
          end
        end
`endif
      end
      StResp: begin
        wb_valid_o = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign x_issue_instr_o = instr_q;
  assign x_issue_rs0_o   = rs0_q;
  assign x_issue_rs1_o   = rs1_q;
  assign x_issue_id_o    = id_q;
  assign x_commit_id_o   = id_q;
  assign wb_id_o         = wb_id_q;
  assign wb_data_o       = wb_data_q;
  assign wb_rd_o         = wb_rd_q;
  assign wb_we_o         = wb_we_q;
  assign wb_exc_o        = wb_exc_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_cvxif_issue_initiator.sv
// Self-checking bench for cvxif_issue_initiator: directed scenarios plus
// randomized transactions. Each transaction's expected cycle-by-cycle
// observations are derived from its chosen stimulus (delays, accept,
// writeback, flush points, wrong-id results).
module tb_cvxif_issue_initiator;

`ifdef CVXIF_ISSUE_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        offload_valid;
  logic        offload_ready;
  logic [31:0] offload_instr;
  logic [63:0] offload_rs0, offload_rs1;
  logic [2:0]  offload_id;
  logic        issue_valid, issue_ready;
  logic [31:0] issue_instr;
  logic [63:0] issue_rs0, issue_rs1;
  logic [2:0]  issue_id;
  logic        issue_accept, issue_wbk;
  logic        commit_valid, commit_kill;
  logic [2:0]  commit_id;
  logic        res_valid, res_ready;
  logic [2:0]  res_id;
  logic [63:0] res_data;
  logic [4:0]  res_rd;
  logic        res_we;
  logic        wb_valid;
  logic [2:0]  wb_id;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we, wb_exc, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cvxif_issue_initiator #(.XLEN(64), .IdWidth(3), .TimeoutCycles(TO)) u_dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .flush_i             (flush),
    .offload_valid_i     (offload_valid),
    .offload_ready_o     (offload_ready),
    .offload_instr_i     (offload_instr),
    .offload_rs0_i       (offload_rs0),
    .offload_rs1_i       (offload_rs1),
    .offload_id_i        (offload_id),
    .x_issue_valid_o     (issue_valid),
    .x_issue_ready_i     (issue_ready),
    .x_issue_instr_o     (issue_instr),
    .x_issue_rs0_o       (issue_rs0),
    .x_issue_rs1_o       (issue_rs1),
    .x_issue_id_o        (issue_id),
    .x_issue_accept_i    (issue_accept),
    .x_issue_writeback_i (issue_wbk),
    .x_commit_valid_o    (commit_valid),
    .x_commit_id_o       (commit_id),
    .x_commit_kill_o     (commit_kill),
    .x_result_valid_i    (res_valid),
    .x_result_ready_o    (res_ready),
    .x_result_id_i       (res_id),
    .x_result_data_i     (res_data),
    .x_result_rd_i       (res_rd),
    .x_result_we_i       (res_we),
    .wb_valid_o          (wb_valid),
    .wb_id_o             (wb_id),
    .wb_data_o           (wb_data),
    .wb_rd_o             (wb_rd),
    .wb_we_o             (wb_we),
    .wb_exc_o            (wb_exc),
    .busy_o              (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Drives one offload through the whole exchange. Every path returns at a
  // falling edge; the caller advances to the next rising edge.
  task automatic run_txn(
    input logic [31:0] t_instr, input logic [63:0] t_rs0, input logic [63:0] t_rs1,
    input logic [2:0] t_id, input int rdy_dly, input bit acc, input bit wbk,
    input int flush_iss, input bit flush_com, input int n_wrong, input int res_dly,
    input bit flush_wait, input logic [63:0] t_data, input logic [4:0] t_rd, input bit t_we);
    bit killed;
    offload_valid = 1'b1;
    offload_instr = t_instr;
    offload_rs0   = t_rs0;
    offload_rs1   = t_rs1;
    offload_id    = t_id;
    mid();
    check_eq("offload_ready", offload_ready, 1);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_issue_valid", issue_valid, 0);
    tick();
    offload_valid = 1'b0;
    offload_instr = $urandom;
    offload_rs0   = {$urandom, $urandom};
    offload_rs1   = {$urandom, $urandom};
    offload_id    = 3'($urandom);
    killed = 1'b0;
    for (int k = 0; k <= rdy_dly; k++) begin
      issue_ready  = (k == rdy_dly);
      flush        = (k == flush_iss);
      if (k == flush_iss) killed = 1'b1;
      issue_accept = (k == rdy_dly) ? acc : 1'($urandom);
      issue_wbk    = (k == rdy_dly) ? wbk : 1'($urandom);
      mid();
      check_eq("issue_valid", issue_valid, 1);
      check_eq("issue_instr", issue_instr, t_instr);
      check_eq("issue_rs0", issue_rs0, t_rs0);
      check_eq("issue_rs1", issue_rs1, t_rs1);
      check_eq("issue_id", issue_id, t_id);
      check_eq("issue_no_commit", commit_valid, 0);
      check_eq("issue_no_wb", wb_valid, 0);
      tick();
    end
    issue_ready = 1'b0;
    flush       = 1'b0;
    if (!acc) begin
      mid();
      check_eq("reject_no_commit", commit_valid, 0);
      if (killed) begin
        check_eq("reject_kill_no_wb", wb_valid, 0);
        check_eq("reject_kill_busy", busy, 0);
        return;
      end
      check_eq("reject_wb_valid", wb_valid, 1);
      check_eq("reject_wb_exc", wb_exc, 1);
      check_eq("reject_wb_we", wb_we, 0);
      check_eq("reject_wb_id", wb_id, t_id);
      tick();
      mid();
      check_eq("reject_busy_after", busy, 0);
      check_eq("reject_wb_single", wb_valid, 0);
      return;
    end
    flush = flush_com;
    mid();
    check_eq("commit_valid", commit_valid, 1);
    check_eq("commit_id", commit_id, t_id);
    check_eq("commit_kill", commit_kill, killed | flush_com);
    check_eq("commit_no_wb", wb_valid, 0);
    tick();
    flush = 1'b0;
    if (killed || flush_com) begin
      mid();
      check_eq("killed_no_wb", wb_valid, 0);
      check_eq("killed_busy", busy, 0);
      check_eq("killed_commit_once", commit_valid, 0);
      return;
    end
    if (!wbk) begin
      mid();
      check_eq("nowb_valid", wb_valid, 1);
      check_eq("nowb_exc", wb_exc, 0);
      check_eq("nowb_we", wb_we, 0);
      check_eq("nowb_id", wb_id, t_id);
      tick();
      mid();
      check_eq("nowb_busy_after", busy, 0);
      return;
    end
    for (int k = 0; k < n_wrong + res_dly; k++) begin
      flush     = flush_wait && (k == 0);
      res_valid = (k < n_wrong);
      res_id    = t_id ^ 3'd7;
      res_data  = {$urandom, $urandom};
      res_rd    = 5'($urandom);
      res_we    = 1'b1;
      mid();
      check_eq("wait_ready", res_ready, 1);
      check_eq("wait_no_wb", wb_valid, 0);
      check_eq("wait_busy", busy, 1);
      tick();
    end
    flush     = flush_wait && (n_wrong + res_dly == 0);
    res_valid = 1'b1;
    res_id    = t_id;
    res_data  = t_data;
    res_rd    = t_rd;
    res_we    = t_we;
    mid();
    check_eq("match_ready", res_ready, 1);
    check_eq("match_no_wb", wb_valid, 0);
    tick();
    res_valid = 1'b0;
    flush     = 1'b0;
    res_data  = {$urandom, $urandom};
    mid();
    if (flush_wait) begin
      check_eq("drop_no_wb", wb_valid, 0);
      check_eq("drop_busy", busy, 0);
      return;
    end
    check_eq("wb_valid", wb_valid, 1);
    check_eq("wb_data", wb_data, t_data);
    check_eq("wb_rd", wb_rd, t_rd);
    check_eq("wb_we", wb_we, t_we);
    check_eq("wb_exc", wb_exc, 0);
    check_eq("wb_id", wb_id, t_id);
    tick();
    mid();
    check_eq("wb_single_pulse", wb_valid, 0);
    check_eq("wb_data_hold", wb_data, t_data);
    check_eq("wb_busy_after", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; offload_valid = 1'b0; offload_instr = '0;
    offload_rs0 = '0; offload_rs1 = '0; offload_id = '0; issue_ready = 1'b0;
    issue_accept = 1'b0; issue_wbk = 1'b0; res_valid = 1'b0; res_id = '0;
    res_data = '0; res_rd = '0; res_we = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mid();
    check_eq("rst_offload_ready", offload_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_issue_valid", issue_valid, 0);
    check_eq("rst_issue_instr", issue_instr, 0);
    check_eq("rst_commit_valid", commit_valid, 0);
    check_eq("rst_result_ready", res_ready, 0);
    check_eq("rst_wb_valid", wb_valid, 0);
    check_eq("rst_wb_data", wb_data, 0);
    check_eq("rst_wb_exc", wb_exc, 0);
    tick();

    // Accepted writeback at minimum latency; wb pulse lands four cycles after capture.
    run_txn(32'h0000_200B, 64'd5, 64'd7, 3'd2, 0, 1, 1, -1, 0, 0, 0, 0, 64'hC, 5'd10, 1);
    tick();
    // Issue backpressure for five cycles.
    run_txn(32'h1234_567B, 64'hAA, 64'hBB, 3'd4, 5, 1, 1, -1, 0, 0, 1, 0, 64'h99, 5'd3, 1);
    tick();
    // Rejected instruction.
    run_txn(32'hDEAD_000B, 64'd1, 64'd2, 3'd1, 0, 0, 1, -1, 0, 0, 0, 0, 64'h0, 5'd0, 0);
    tick();
    // Flush while the issue is backpressured; handshake three cycles later.
    run_txn(32'h0000_300B, 64'd3, 64'd4, 3'd6, 3, 1, 1, 0, 0, 0, 0, 0, 64'h0, 5'd0, 0);
    tick();
    // Result with id 5 while waiting on id 2 is swallowed.
    run_txn(32'h0000_200B, 64'd8, 64'd9, 3'd2, 0, 1, 1, -1, 0, 1, 0, 0, 64'h33, 5'd7, 1);
    tick();
    // Accepted without writeback.
    run_txn(32'h0000_400B, 64'd1, 64'd1, 3'd3, 1, 1, 0, -1, 0, 0, 0, 0, 64'h0, 5'd0, 0);
    tick();

    // Flush while idle blocks capture.
    flush = 1'b1; offload_valid = 1'b1;
    mid();
    check_eq("idle_flush_ready", offload_ready, 0);
    tick();
    flush = 1'b0; offload_valid = 1'b0;
    mid();
    check_eq("idle_flush_no_capture", busy, 0);
    tick();

    // Reset in the middle of an issue abandons it without commit or wb.
    offload_valid = 1'b1; offload_instr = 32'hCAFE_000B; offload_id = 3'd5;
    tick();
    offload_valid = 1'b0;
    mid();
    check_eq("pre_rst_busy", busy, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mid();
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_issue_valid", issue_valid, 0);
    check_eq("midrst_instr_cleared", issue_instr, 0);
    check_eq("midrst_commit", commit_valid, 0);
    check_eq("midrst_wb", wb_valid, 0);
    check_eq("midrst_ready", offload_ready, 1);
    tick();

`ifdef CVXIF_ISSUE_TIMEOUT_EN
    // Timeout: no result within TO waiting cycles, then a late result is drained.
    offload_valid = 1'b1; offload_instr = 32'h0000_200B; offload_id = 3'd2;
    tick();
    offload_valid = 1'b0; issue_ready = 1'b1; issue_accept = 1'b1; issue_wbk = 1'b1;
    tick();
    issue_ready = 1'b0;
    mid();
    check_eq("to_commit", commit_valid, 1);
    tick();
    for (int k = 0; k < int'(TO); k++) begin
      mid();
      check_eq("to_wait_no_wb", wb_valid, 0);
      check_eq("to_wait_ready", res_ready, 1);
      tick();
    end
    mid();
    check_eq("to_wb_valid", wb_valid, 1);
    check_eq("to_wb_exc", wb_exc, 1);
    check_eq("to_wb_we", wb_we, 0);
    tick();
    res_valid = 1'b1; res_id = 3'd2; res_data = 64'h77; res_rd = 5'd1; res_we = 1'b1;
    mid();
    check_eq("to_late_ready", res_ready, 1);
    tick();
    res_valid = 1'b0;
    mid();
    check_eq("to_late_no_wb", wb_valid, 0);
    check_eq("to_stale_cleared", res_ready, 0);
    check_eq("to_idle", busy, 0);
    tick();
`endif

    for (int n = 0; n < 40; n++) begin
      int  rdy;
      int  fi;
      bit  acc, wbk, fc, fw;
      rdy = $urandom_range(0, 3);
      acc = ($urandom_range(0, 9) < 8);
      wbk = ($urandom_range(0, 9) < 7);
      fi  = ($urandom_range(0, 9) < 2) ? $urandom_range(0, rdy) : -1;
      fc  = ($urandom_range(0, 9) == 0);
      fw  = ($urandom_range(0, 9) < 2);
      run_txn($urandom, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom), rdy, acc,
              wbk, fi, fc, $urandom_range(0, 1), $urandom_range(0, 1), fw,
              {$urandom, $urandom}, 5'($urandom), 1'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
